// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the convolution row scheduler
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_PRIME,
        ST_RUN,
        ST_DONE
    } conv_sched_state_t;

    localparam logic [1:0] FLOW_NONE = 2'b00;
    localparam logic [1:0] FLOW_ROW1 = 2'b01;
    localparam logic [1:0] FLOW_ROW2 = 2'b10;
    localparam logic [1:0] FLOW_ROW3 = 2'b11;

    localparam int NUM_BANKS   = 3;
    localparam int KERNEL_ROWS = 3;

    // Weight beat k (0..2) preloads kernel row k+1.
    function automatic logic [1:0] flow_for_beat(input logic [1:0] k);
        case (k)
            2'd0:    return FLOW_ROW1;
            2'd1:    return FLOW_ROW2;
            default: return FLOW_ROW3;
        endcase
    endfunction

endpackage

// File: rtl/bank_rotator.sv
// rtl/bank_rotator.sv - mod-3 line-buffer write pointer with one-hot write and read masks
module bank_rotator
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 advance,
    output logic [NUM_BANKS-1:0] wr_onehot,
    output logic [NUM_BANKS-1:0] rd_mask
);

    logic [1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= 2'd0;
        end else if (advance) begin
            wr_ptr <= (wr_ptr == 2'(NUM_BANKS - 1)) ? 2'd0 : wr_ptr + 2'd1;
        end
    end

    // The two banks not being written hold the previous two image rows.
    always_comb begin
        wr_onehot = NUM_BANKS'(1) << wr_ptr;
        rd_mask   = ~wr_onehot;
    end

endmodule

// File: rtl/conv_row_scheduler.sv
// rtl/conv_row_scheduler.sv - per-layer row sequencer for the 3x3 PE array and line-buffer banks
module conv_row_scheduler
    import conv_pkg::*;
#(
    parameter int IMAGE_ROWS = 32,
    parameter int ROW_IDX_W  = $clog2(IMAGE_ROWS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 PE_en,
    output logic                 PE_init_mode,
    output logic [1:0]           PE_init_data_flow_counter,
    output logic [NUM_BANKS-1:0] mem_wr_en,
    output logic [NUM_BANKS-1:0] mem_rd_en,
    output logic                 out_row_valid,
    output logic [ROW_IDX_W-1:0] out_row_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(IMAGE_ROWS);

    generate
        if (IMAGE_ROWS < 3) begin : g_bad_rows
            $fatal(1, "conv_row_scheduler: IMAGE_ROWS must be at least 3");
        end
    endgenerate

    conv_sched_state_t    state;
    logic [1:0]           beat_cnt;
    logic [CNT_W-1:0]     row_cnt;
    logic                 streaming;
    logic                 beat;
    logic [NUM_BANKS-1:0] wr_onehot;
    logic [NUM_BANKS-1:0] rd_mask;

    assign streaming = (state == ST_LOAD_W) || (state == ST_PRIME) || (state == ST_RUN);
    assign in_ready  = rst_n && !abort && streaming;
    assign beat      = in_valid && in_ready;

    bank_rotator u_rot (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (abort || (state == ST_IDLE && start)),
        .advance   (beat && (state == ST_PRIME || state == ST_RUN)),
        .wr_onehot (wr_onehot),
        .rd_mask   (rd_mask)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            state                     <= ST_IDLE;
            beat_cnt                  <= 2'd0;
            row_cnt                   <= '0;
            PE_en                     <= 1'b0;
            PE_init_mode              <= 1'b0;
            PE_init_data_flow_counter <= FLOW_NONE;
            mem_wr_en                 <= '0;
            mem_rd_en                 <= '0;
            out_row_valid             <= 1'b0;
            out_row_idx               <= '0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
        end else begin
            PE_en                     <= 1'b0;
            PE_init_data_flow_counter <= FLOW_NONE;
            mem_wr_en                 <= '0;
            mem_rd_en                 <= '0;
            out_row_valid             <= 1'b0;
            done                      <= 1'b0;
            // Preload mode survives stalls between weight beats.
            PE_init_mode              <= (state == ST_LOAD_W) ? PE_init_mode : 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD_W;
                        beat_cnt <= 2'd0;
                        row_cnt  <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_LOAD_W: begin
                    if (beat) begin
                        PE_en                     <= 1'b1;
                        PE_init_mode              <= 1'b1;
                        PE_init_data_flow_counter <= flow_for_beat(beat_cnt);
                        if (beat_cnt == 2'(KERNEL_ROWS - 1)) begin
                            state    <= ST_PRIME;
                            beat_cnt <= 2'd0;
                        end else begin
                            beat_cnt <= beat_cnt + 2'd1;
                        end
                    end
                end
                ST_PRIME: begin
                    if (beat) begin
                        mem_wr_en <= wr_onehot;
                        if (beat_cnt == 2'(KERNEL_ROWS - 2)) begin
                            state    <= ST_RUN;
                            beat_cnt <= 2'd0;
                            row_cnt  <= CNT_W'(KERNEL_ROWS - 1);
                        end else begin
                            beat_cnt <= beat_cnt + 2'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        PE_en         <= 1'b1;
                        mem_wr_en     <= wr_onehot;
                        mem_rd_en     <= rd_mask;
                        out_row_valid <= 1'b1;
                        out_row_idx   <= ROW_IDX_W'(row_cnt - CNT_W'(KERNEL_ROWS - 1));
                        if (row_cnt == CNT_W'(IMAGE_ROWS - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            row_cnt <= row_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/conv_row_scheduler.md
# conv_row_scheduler

Row-level sequencer for the 3x3 convolution PE array and its three line-buffer banks. It consumes a row-beat stream (three weight rows, then IMAGE_ROWS image rows) through a valid/ready handshake. For each accepted beat it produces the PE control word (PE_en, PE_init_mode, PE_init_data_flow_counter) and the bank write/read enables, one cycle later, aligned with the datapath input register stage. It sits between the row fetch unit and the PE array / line-buffer banks, and owns the whole per-layer sequence from weight preload to done.

## Interface
- IMAGE_ROWS, default 32: image rows per layer pass; legal range 3..1023.
- ROW_IDX_W, default $clog2(IMAGE_ROWS): width of out_row_idx.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a layer pass; sampled only in IDLE.
- abort  in  1  synchronous cancel; overrides everything except reset.
- in_valid  in  1  upstream has a row beat on the data bus.
- in_ready  out  1  scheduler accepts the beat this cycle; a beat transfers when in_valid && in_ready.
- PE_en  out  1  PE array enable.
- PE_init_mode  out  1  PE weight-preload mode.
- PE_init_data_flow_counter  out  2  preload row select: 00 none, 01 row 1, 10 row 2, 11 row 3.
- mem_wr_en  out  3  one-hot bank write enable.
- mem_rd_en  out  3  bank read enables.
- out_row_valid  out  1  one-cycle pulse: PE array computes an output row this cycle.
- out_row_idx  out  ROW_IDX_W  index of that output row, 0..IMAGE_ROWS-3.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD_W, PRIME, RUN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → LOAD_W; clears beat counter, wr_ptr=0 and row_cnt=0.
- LOAD_W:
  - in_ready=1.
  - Accepted beat k (0..2) → next cycle PE_en=1, PE_init_mode=1, flow counter=k+1, mem enables 000.
  - After the third beat → PRIME.
- PRIME:
  - in_ready=1.
  - Accepted beat → next cycle mem_wr_en=onehot(wr_ptr), PE_en=0, PE_init_mode=0, flow 00, mem_rd_en=000.
  - wr_ptr advances 0→1→2→0.
  - After two beats → RUN, with row_cnt=2.
- RUN:
  - in_ready=1.
  - Accepted beat → next cycle PE_en=1, PE_init_mode=0, flow 00, mem_wr_en=onehot(wr_ptr), mem_rd_en=~onehot(wr_ptr)&3'b111.
  - Same cycle: out_row_valid=1, out_row_idx=row_cnt-2.
  - wr_ptr wraps; row_cnt increments.
  - Beat with row_cnt==IMAGE_ROWS-1 → DONE.
- DONE:
  - in_ready=0.
  - done=1 for exactly this cycle → IDLE.
- Stall (in_valid=0 in LOAD_W/PRIME/RUN): the next cycle has PE_en=0, all mem enables 000, out_row_valid=0, flow 00. PE_init_mode holds 1 during a LOAD_W stall. State and counters hold.
- start while not IDLE: ignored.
- abort:
  - Next cycle: state IDLE, all control outputs 0, busy=0, no done pulse.
  - A beat offered in the abort cycle is not accepted (in_ready forced 0).
- Reset: same as abort, plus start ignored during reset.

## Timing
- All outputs are registered except in_ready, which is a combinational decode of the current state and abort.
- Control latency: beat accepted at edge N → control word valid in cycle N+1, for one cycle only.
- Throughput: one beat per cycle; no bubbles inserted by the scheduler.
- Minimum pass length with continuous valid: 1 (start) + 3 + 2 + (IMAGE_ROWS-2) + 1 cycles. done is asserted in the cycle after the last control word.
- busy rises the cycle after start is sampled and falls the cycle after DONE.
- Reset values: in_ready 0, PE_en 0, PE_init_mode 0, flow 00, mem_wr_en 000, mem_rd_en 000, out_row_valid 0, out_row_idx 0, busy 0, done 0.
- mem_wr_en is always one-hot or zero. mem_rd_en is never nonzero outside RUN.

## Structure
- Shared package conv_pkg holds:
  - state enum conv_sched_state_t;
  - flow-counter constants FLOW_NONE/ROW1/ROW2/ROW3;
  - NUM_BANKS=3 and KERNEL_ROWS=3.
- One sub-module, bank_rotator: a mod-3 wr_ptr with advance and clear inputs, producing onehot(wr_ptr) and the read mask.
- Elaboration check: IMAGE_ROWS<3 is a fatal error.

## Test plan
- IMAGE_ROWS=5, start, in_valid held high → flow 01,10,11 with init_mode=1; then writes 001,010; then RUN wr/rd 100/011, 001/110, 010/101 with out_row_idx 0,1,2; done one cycle later; busy falls after.
- Same pass with in_valid low every other cycle → identical control sequence with zero-enable gaps; PE_init_mode stays 1 through LOAD_W gaps.
- abort asserted during the second RUN beat → in_ready=0 in that cycle, next cycle all outputs 0, no done; a following start runs a full clean pass from wr_ptr=0.
- start pulsed again mid-RUN → no effect; pass completes normally.
- rst_n low for one cycle mid-PRIME → all outputs at reset values next cycle; the next start is processed normally.
- IMAGE_ROWS=32 → 30 out_row_valid pulses, out_row_idx 0..29; wr_ptr wraps 10 times during RUN; done after the 32nd image beat.
